// File: rtl/enable_table_loader_if.sv
// enable_table_loader_if: config-byte stream in, enable-table write port and load status out.
interface enable_table_loader_if #(parameter int ADDR_BITS = 9);
  logic start, abort, in_valid, in_ready, table_we, ram_disable, rom_disable, busy, done;
  logic [7:0] in_data;
  logic [1:0] table_val;
  logic [ADDR_BITS-1:0] table_write_addr;
  modport master(
    output start, abort, in_data, in_valid,
    input in_ready, table_we, table_val, table_write_addr, ram_disable, rom_disable, busy, done
  );
  modport slave(
    input start, abort, in_data, in_valid,
    output in_ready, table_we, table_val, table_write_addr, ram_disable, rom_disable, busy, done
  );
endinterface

// File: rtl/enable_table_loader.sv
// enable_table_loader: unpacks config bytes into 2-bit enable-table writes,
// holding the RAM/ROM paths off until a complete table has landed.
module enable_table_loader #(
  parameter int NUM_ENTRIES = 512,
  parameter int ADDR_BITS = 9
) (
  input logic fpga_clk,
  input logic reset,
  enable_table_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_ENTRIES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] sub, sub_n, val, val_n;
  logic [7:0] data, data_n;
  logic [ADDR_BITS-1:0] addr, addr_n;
  logic dis, dis_n, last;
  // a byte ends early when the table fills mid-byte
  assign last = sub == 2'd3 || cnt == LAST;
  always_ff @(posedge fpga_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sub <= '0;
      val <= '0;
      data <= '0;
      addr <= '0;
      dis <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sub <= sub_n;
      val <= val_n;
      data <= data_n;
      addr <= addr_n;
      dis <= dis_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sub_n = sub;
    val_n = val;
    data_n = data;
    addr_n = addr;
    dis_n = dis;
    case (state)
      IDLE: if (bus.start) begin
        state_n = LOAD;
        cnt_n = '0;
        dis_n = 1'b1;
      end
      LOAD: if (bus.abort) state_n = IDLE;
      else if (bus.in_valid) begin
        state_n = WRITE;
        data_n = bus.in_data;
        sub_n = '0;
        val_n = bus.in_data[1:0];
        addr_n = cnt[ADDR_BITS-1:0];
      end
      WRITE: if (bus.abort) state_n = IDLE;
      else begin
        cnt_n = cnt + 1'b1;
        sub_n = sub + 1'b1;
        val_n = last ? val : data[{sub_n, 1'b0} +: 2];
        addr_n = last ? addr : cnt_n[ADDR_BITS-1:0];
        state_n = !last ? WRITE : cnt == LAST ? DONE : LOAD;
        dis_n = !(last && cnt == LAST);
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.in_ready = state == LOAD;
  assign bus.table_we = state == WRITE;
  assign bus.busy = state == LOAD || state == WRITE;
  assign bus.done = state == DONE;
  assign bus.table_val = val;
  assign bus.table_write_addr = addr;
  assign bus.ram_disable = dis;
  assign bus.rom_disable = dis;
endmodule

// File: tb/tb_enable_table_loader.sv
// tb_enable_table_loader: vector table, scoreboard of expected writes, and directed
// abort/reset/short-table sequences for enable_table_loader.
module tb_enable_table_loader;
  logic fpga_clk = 0;
  logic reset = 1;
  always #5 fpga_clk = ~fpga_clk;
  enable_table_loader_if #(.ADDR_BITS(9)) b();
  enable_table_loader_if #(.ADDR_BITS(3)) s();
  enable_table_loader dut (.fpga_clk(fpga_clk), .reset(reset), .bus(b.slave));
  enable_table_loader #(.NUM_ENTRIES(6), .ADDR_BITS(3)) dut6 (.fpga_clk(fpga_clk), .reset(reset), .bus(s.slave));
  typedef struct { int addr; int val; } wr_t;
  typedef struct { logic [7:0] d; int gap; int v[4]; } vec_t;
  wr_t exp_q[$];
  wr_t mon_e;
  vec_t vecs[7];
  int s_addr[$];
  int s_val[$];
  int n_cmp = 0, n_err = 0, m_idx = 0, wr_cnt = 0, done_cnt = 0, s_done_cnt = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  bit acc_seen = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic void model_byte(input logic [7:0] d);
    wr_t w;
    for (int j = 0; j < 4; j++)
      if (m_idx < 512) begin
        w.addr = m_idx;
        w.val = int'((d >> (2 * j)) & 8'd3);
        exp_q.push_back(w);
        m_idx++;
      end
  endfunction
  always @(posedge fpga_clk) cyc++;
  always @(negedge fpga_clk)
    if (!reset) begin
      if (b.table_we) begin
        wr_cnt++;
        chk("write_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", b.table_write_addr, mon_e.addr);
          chk("wr_val", b.table_val, mon_e.val);
        end
      end
      if (b.in_valid && b.in_ready && !acc_seen) begin
        acc_seen = 1;
        acc_cyc = cyc;
      end
      if (b.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (s.table_we) begin
        s_addr.push_back(int'(s.table_write_addr));
        s_val.push_back(int'(s.table_val));
      end
      if (s.done) s_done_cnt++;
    end
  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask
  task automatic begin_load(input logic ab);
    m_idx = 0;
    exp_q.delete();
    wr_cnt = 0;
    done_cnt = 0;
    acc_seen = 0;
    b.start = 1;
    b.abort = ab;
    tick();
    b.start = 0;
    b.abort = 0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    int k = 0;
    model_byte(d);
    b.in_data = d;
    b.in_valid = 1;
    @(negedge fpga_clk);
    while (!b.in_ready && k < 50) begin
      @(negedge fpga_clk);
      k++;
    end
    chk("in_ready_seen", b.in_ready, 1);
    @(posedge fpga_clk);
    #1 b.in_valid = 0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge fpga_clk);
      k++;
    end while (!b.done && k < 40);
    chk({tag, "_done_pulse"}, b.done, 1);
    chk({tag, "_ram_dis_in_done"}, b.ram_disable, 0);
    chk({tag, "_rom_dis_in_done"}, b.rom_disable, 0);
    chk({tag, "_busy_in_done"}, b.busy, 0);
    @(negedge fpga_clk);
    chk({tag, "_done_one_cycle"}, b.done, 0);
    chk({tag, "_ram_dis_idle"}, b.ram_disable, 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, b.table_we, 0);
    chk({tag, "_ready"}, b.in_ready, 0);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_done"}, b.done, 0);
    chk({tag, "_val"}, b.table_val, 0);
    chk({tag, "_addr"}, b.table_write_addr, 0);
    chk({tag, "_ram_dis"}, b.ram_disable, 1);
    chk({tag, "_rom_dis"}, b.rom_disable, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{8'hE4, 0, '{0, 1, 2, 3}};
    vecs[1] = '{8'h1B, 10, '{3, 2, 1, 0}};
    vecs[2] = '{8'h1B, 10, '{3, 2, 1, 0}};
    vecs[3] = '{8'hFF, 3, '{3, 3, 3, 3}};
    vecs[4] = '{8'h00, 1, '{0, 0, 0, 0}};
    vecs[5] = '{8'hA5, 0, '{1, 1, 2, 2}};
    vecs[6] = '{8'h72, 2, '{2, 0, 3, 1}};
    {b.start, b.abort, b.in_valid, b.in_data} = '0;
    {s.start, s.abort, s.in_valid, s.in_data} = '0;
    @(negedge fpga_clk);
    chk_reset("reset");
    chk("reset6_ram_dis", s.ram_disable, 1);
    tick();
    reset = 0;
    repeat (3) tick();
    chk("idle_ram_dis_before_start", b.ram_disable, 1);
    // full back-to-back load of 0xE4
    begin_load(0);
    for (int i = 0; i < 128; i++) send_byte(8'hE4);
    wait_done("A");
    chk("A_writes", wr_cnt, 512);
    chk("A_queue_left", exp_q.size(), 0);
    chk("A_done_count", done_cnt, 1);
    chk("A_latency", done_cyc - acc_cyc, 640);
    // vector table with gaps, random tail, stray start mid-load
    tick();
    begin_load(0);
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          repeat (vecs[i].gap) begin
            @(negedge fpga_clk);
            chk("B_gap_ready", b.in_ready, 1);
            chk("B_gap_we", b.table_we, 0);
            tick();
          end
          send_byte(vecs[i].d);
          for (int j = 0; j < 4; j++) begin
            @(negedge fpga_clk);
            chk("B_vec_we", b.table_we, 1);
            chk("B_vec_val", b.table_val, vecs[i].v[j]);
          end
          tick();
        end
        for (int i = 7; i < 128; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
          send_byte(8'($urandom));
        end
      end
      begin
        repeat (300) @(posedge fpga_clk);
        #1 b.start = 1;
        tick();
        b.start = 0;
      end
    join
    wait_done("B");
    chk("B_writes", wr_cnt, 512);
    chk("B_queue_left", exp_q.size(), 0);
    chk("B_done_count", done_cnt, 1);
    // abort at entry 200
    tick();
    begin_load(0);
    for (int i = 0; i < 51; i++) send_byte(8'hE4);
    b.abort = 1;
    @(negedge fpga_clk);
    chk("C_addr_at_abort", b.table_write_addr, 200);
    tick();
    b.abort = 0;
    @(negedge fpga_clk);
    exp_q.delete();
    chk("C_we_after_abort", b.table_we, 0);
    chk("C_busy_after_abort", b.busy, 0);
    chk("C_done_after_abort", b.done, 0);
    chk("C_ram_dis_after_abort", b.ram_disable, 1);
    chk("C_rom_dis_after_abort", b.rom_disable, 1);
    repeat (5) @(negedge fpga_clk);
    chk("C_no_done", done_cnt, 0);
    tick();
    begin_load(1);
    @(negedge fpga_clk);
    chk("C_start_beats_abort", b.busy, 1);
    tick();
    send_byte(8'h1B);
    @(negedge fpga_clk);
    chk("C_restart_addr", b.table_write_addr, 0);
    // reset while writing entry 3
    repeat (3) @(negedge fpga_clk);
    chk("D_addr_before_reset", b.table_write_addr, 3);
    chk("D_we_before_reset", b.table_we, 1);
    #1 reset = 1;
    #1 chk_reset("D_async");
    exp_q.delete();
    tick();
    reset = 0;
    tick();
    begin_load(0);
    send_byte(8'h1B);
    @(negedge fpga_clk);
    chk("D_reload_addr", b.table_write_addr, 0);
    chk("D_reload_val", b.table_val, 3);
    chk("D_reload_dis", b.ram_disable, 1);
    // six-entry table
    tick();
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    s_addr.delete();
    s_val.delete();
    s_done_cnt = 0;
    s.start = 1;
    tick();
    s.start = 0;
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      s.in_data = 8'hFF;
      s.in_valid = 1;
      @(negedge fpga_clk);
      while (!s.in_ready && k < 50) begin
        @(negedge fpga_clk);
        k++;
      end
      chk("E_ready_seen", s.in_ready, 1);
      @(posedge fpga_clk);
      #1 s.in_valid = 0;
    end
    for (int k = 0; k < 40 && !s.done; k++) @(negedge fpga_clk);
    chk("E_done_pulse", s.done, 1);
    chk("E_ram_dis_in_done", s.ram_disable, 0);
    repeat (3) @(negedge fpga_clk);
    chk("E_write_count", s_addr.size(), 6);
    for (int i = 0; i < s_addr.size(); i++) begin
      chk("E_addr", s_addr[i], i);
      chk("E_val", s_val[i], 3);
    end
    chk("E_done_count", s_done_cnt, 1);
    chk("E_ready_after", s.in_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
